// File: rtl/vdf_sqr_loop_ctrl.sv
// Iterated modular-squaring controller: computes x^(2^T) mod N by repeatedly
// squaring through an external multiplier, one request in flight at a time.
module vdf_sqr_loop_ctrl #(
   parameter int BITS      = 1024,
   parameter int ITER_W    = 32,
   parameter int TIMEOUT_W = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_val,
   output logic              o_rdy,
   input  logic [BITS-1:0]   i_dat,
   input  logic [ITER_W-1:0] i_iter,
   output logic              o_val,
   input  logic              i_rdy,
   output logic [BITS-1:0]   o_dat,
   output logic              o_err,
   output logic [ITER_W-1:0] o_iter_left,
   output logic              o_mul_val,
   input  logic              i_mul_rdy,
   output logic [BITS-1:0]   o_mul_dat_a,
   output logic [BITS-1:0]   o_mul_dat_b,
   input  logic              i_mul_val,
   input  logic [BITS-1:0]   i_mul_dat,
   output logic              o_mul_rdy
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [TIMEOUT_W-1:0] WD_MAX = '1;

   logic [1:0]           state;
   logic [BITS-1:0]      x;
   logic [ITER_W-1:0]    cnt;
   logic [TIMEOUT_W-1:0] wd;

   assign o_rdy       = (state == IDLE);
   // The multiplier is never back-pressured; only reset holds it off.
   assign o_mul_rdy   = !i_rst;
   assign o_mul_dat_a = x;
   assign o_mul_dat_b = x;
   assign o_iter_left = cnt;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= IDLE;
         x         <= '0;
         cnt       <= '0;
         wd        <= '0;
         o_val     <= 1'b0;
         o_dat     <= '0;
         o_err     <= 1'b0;
         o_mul_val <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (i_val) begin
                  x     <= i_dat;
                  cnt   <= i_iter;
                  o_err <= 1'b0;
                  if (i_iter == '0) begin
                     state <= DONE;
                     o_val <= 1'b1;
                     o_dat <= i_dat;
                  end else begin
                     state     <= ISSUE;
                     o_mul_val <= 1'b1;
                  end
               end
            end
            ISSUE: begin
               if (i_mul_rdy) begin
                  o_mul_val <= 1'b0;
                  wd        <= '0;
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (i_mul_val) begin
                  x   <= i_mul_dat;
                  cnt <= cnt - ITER_W'(1);
                  if (cnt == ITER_W'(1)) begin
                     state <= DONE;
                     o_val <= 1'b1;
                     o_dat <= i_mul_dat;
                  end else begin
                     state     <= ISSUE;
                     o_mul_val <= 1'b1;
                  end
               end else if (wd == WD_MAX) begin
                  // Lost response: report the last good value and give up.
                  o_err <= 1'b1;
                  o_dat <= x;
                  o_val <= 1'b1;
                  cnt   <= '0;
                  state <= DONE;
               end else begin
                  wd <= wd + TIMEOUT_W'(1);
               end
            end
            DONE: begin
               if (i_rdy) begin
                  o_val <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
         // A result with nothing outstanding is dropped but flagged.
         if (i_mul_val && state != WAIT) o_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vdf_sqr_loop_ctrl.sv
// Scoreboard bench for vdf_sqr_loop_ctrl: random jobs against a modular
// exponentiation reference, with a latency-L multiplier model.
module tb_vdf_sqr_loop_ctrl;
   localparam int BITS = 16;
   localparam int ITER_W = 8;
   localparam int TW = 8;
   localparam int L = 6;
   localparam longint unsigned N = 64'hFFF1;

   logic              clk = 1'b0;
   logic              i_rst, i_val, o_rdy, o_val, i_rdy, o_err;
   logic [BITS-1:0]   i_dat, o_dat, o_mul_dat_a, o_mul_dat_b, i_mul_dat;
   logic [ITER_W-1:0] i_iter, o_iter_left;
   logic              o_mul_val, i_mul_rdy, i_mul_val, o_mul_rdy;

   always #5 clk = ~clk;

   vdf_sqr_loop_ctrl #(.BITS(BITS), .ITER_W(ITER_W), .TIMEOUT_W(TW)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_val(i_val), .o_rdy(o_rdy), .i_dat(i_dat),
      .i_iter(i_iter), .o_val(o_val), .i_rdy(i_rdy), .o_dat(o_dat), .o_err(o_err),
      .o_iter_left(o_iter_left), .o_mul_val(o_mul_val), .i_mul_rdy(i_mul_rdy),
      .o_mul_dat_a(o_mul_dat_a), .o_mul_dat_b(o_mul_dat_b), .i_mul_val(i_mul_val),
      .i_mul_dat(i_mul_dat), .o_mul_rdy(o_mul_rdy)
   );

   int n_chk = 0;
   int n_pass = 0;

   task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   typedef struct {
      logic [BITS-1:0] dat;
      logic            err;
   } exp_t;
   exp_t sb[$];

   function automatic logic [BITS-1:0] ref_pow(input logic [BITS-1:0] x, input int t);
      longint unsigned v = x;
      for (int i = 0; i < t; i++) v = (v * v) % N;
      return v[BITS-1:0];
   endfunction

   // multiplier model state
   bit              drop = 0;
   bit              rnd_rdy = 0;
   int              low_cnt = 0;
   bit              pend = 0;
   int              cd = 0;
   logic [BITS-1:0] res;
   int              xfers = 0;
   int              mul_cycles = 0;
   int              job_t = 0;
   longint unsigned exp_op = 0;
   bit              stalled = 0;

   initial begin
      i_mul_val = 1'b0;
      i_mul_dat = '0;
      i_mul_rdy = 1'b1;
      forever begin
         @(negedge clk);
         if (stalled) begin
            check("stall_hold_val", o_mul_val, 1);
            check("stall_hold_op", o_mul_dat_a, exp_op);
         end
         i_mul_val = 1'b0;
         if (pend) begin
            if (cd == 0) begin
               i_mul_val = 1'b1;
               i_mul_dat = res;
               pend = 0;
            end else cd--;
         end
         if (low_cnt > 0) begin
            i_mul_rdy = 1'b0;
            low_cnt--;
         end else i_mul_rdy = rnd_rdy ? 1'($urandom_range(1)) : 1'b1;
         if (o_mul_val) mul_cycles++;
         if (o_mul_val && i_mul_rdy && !i_rst) begin
            longint unsigned a, b;
            a = o_mul_dat_a;
            b = o_mul_dat_b;
            check("mul_op_a", o_mul_dat_a, exp_op);
            check("mul_op_b", o_mul_dat_b, exp_op);
            check("iter_left", o_iter_left, longint'(job_t - xfers));
            exp_op = (exp_op * exp_op) % N;
            xfers++;
            if (!drop) begin
               pend = 1;
               cd = L - 1;
               res = BITS'((a * b) % N);
            end
         end
         stalled = o_mul_val && !i_mul_rdy && !i_rst;
      end
   end

   // result monitor
   initial begin
      forever begin
         @(negedge clk);
         if (!i_rst && o_val && i_rdy) begin
            if (sb.size() == 0) begin
               n_chk++;
               $display("FAIL unexpected_result: got 0x%0h expected none", o_dat);
            end else begin
               exp_t e;
               e = sb.pop_front();
               check("result_dat", o_dat, e.dat);
               check("result_err", o_err, e.err);
            end
         end
      end
   end

   task automatic start_job(input logic [BITS-1:0] x, input int t);
      int n = 0;
      while (!o_rdy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (!o_rdy) begin
         n_chk++;
         $display("FAIL accept_timeout: got o_rdy=0 expected o_rdy=1");
      end
      exp_op = x;
      xfers = 0;
      mul_cycles = 0;
      job_t = t;
      i_dat = x;
      i_iter = ITER_W'(t);
      i_val = 1'b1;
      @(posedge clk); #1;
      i_val = 1'b0;
      i_dat = BITS'($urandom);
      i_iter = ITER_W'($urandom);
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      while (!o_val && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!o_val) begin
         n_chk++;
         $display("FAIL done_timeout: got o_val=0 after %0d cycles expected o_val=1", lat);
         sb.delete();
      end
   endtask

   task automatic finish_job(input int hold, input logic [BITS-1:0] exp_dat);
      check("done_iter_left", o_iter_left, 0);
      for (int i = 0; i < hold; i++) begin
         check("hold_val", o_val, 1);
         check("hold_dat", o_dat, exp_dat);
         i_val = 1'b1;
         i_dat = BITS'($urandom);
         i_iter = ITER_W'($urandom);
         @(posedge clk); #1;
      end
      i_val = 1'b0;
      i_rdy = 1'b1;
      @(posedge clk); #1;
      i_rdy = 1'b0;
      check("idle_rdy", o_rdy, 1);
      check("idle_val", o_val, 0);
   endtask

   task automatic full_job(input logic [BITS-1:0] x, input int t, input int hold);
      int lat;
      logic [BITS-1:0] e;
      e = ref_pow(x, t);
      sb.push_back('{dat: e, err: 1'b0});
      start_job(x, t);
      wait_done(lat);
      check("xfer_count", xfers, t);
      finish_job(hold, e);
   endtask

   initial begin
      int lat;
      i_rst = 1'b1;
      i_val = 1'b0;
      i_rdy = 1'b0;
      i_dat = '0;
      i_iter = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_rdy", o_rdy, 1);
      check("rst_val", o_val, 0);
      check("rst_mul_val", o_mul_val, 0);
      check("rst_err", o_err, 0);
      check("rst_dat", o_dat, 0);
      check("rst_iter_left", o_iter_left, 0);
      check("rst_mul_rdy", o_mul_rdy, 0);
      i_rst = 1'b0;
      @(posedge clk); #1;
      check("mul_rdy_run", o_mul_rdy, 1);

      // x=3, T=3 -> 3^8 mod N
      check("ref_3_3", ref_pow(16'd3, 3), 16'h19A1);
      full_job(16'd3, 3, 0);

      // T=0 passes x straight through without touching the multiplier
      sb.push_back('{dat: 16'h1234, err: 1'b0});
      start_job(16'h1234, 0);
      wait_done(lat);
      check("t0_fast", lat <= 1, 1);
      check("t0_no_mul", mul_cycles, 0);
      finish_job(1, 16'h1234);

      // long hold in DONE
      check("ref_2_5", ref_pow(16'd2, 5), 16'h00E1);
      full_job(16'd2, 5, 10);

      // multiplier stalls at the start of ISSUE
      low_cnt = 6;
      full_job(16'd5, 2, 0);

      rnd_rdy = 1;
      for (int j = 0; j < 10; j++)
         full_job(BITS'($urandom_range(int'(N) - 1)), $urandom_range(0, 6), $urandom_range(0, 3));
      rnd_rdy = 0;

      // dropped response trips the watchdog
      drop = 1;
      sb.push_back('{dat: 16'h0777, err: 1'b1});
      start_job(16'h0777, 3);
      wait_done(lat);
      drop = 0;
      check("wd_lat_min", lat >= 255, 1);
      check("wd_err", o_err, 1);
      finish_job(2, 16'h0777);
      full_job(16'd7, 1, 0);

      // reset while waiting; the late result becomes a stray
      start_job(16'd9, 3);
      lat = 0;
      while (xfers < 1 && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
      check("rst_test_xfer", xfers, 1);
      @(posedge clk); #1;
      i_rst = 1'b1;
      @(posedge clk); #1;
      check("mid_rst_rdy", o_rdy, 1);
      check("mid_rst_val", o_val, 0);
      check("mid_rst_mul_val", o_mul_val, 0);
      check("mid_rst_iter_left", o_iter_left, 0);
      check("mid_rst_err", o_err, 0);
      i_rst = 1'b0;
      repeat (12) @(posedge clk);
      #1;
      check("stray_err", o_err, 1);
      check("stray_rdy", o_rdy, 1);
      full_job(16'd10, 2, 1);

      check("sb_empty", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
